// File: rtl/phaser_ctrl_pkg.sv
// Shared opcodes, widths and FSM encoding for the PHASER_IN tap sequencer.
package phaser_ctrl_pkg;

    localparam int unsigned TAP_W = 6;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned CNT_W = 8;

    localparam logic [OP_W-1:0] OP_SET_FINE    = 2'b00;
    localparam logic [OP_W-1:0] OP_LOAD_COARSE = 2'b01;
    localparam logic [OP_W-1:0] OP_READ_COARSE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_SETTLE,
        ST_LOAD,
        ST_RD_PULSE,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap,
                                                  input logic             inc);
        return inc ? tap + TAP_W'(1) : tap - TAP_W'(1);
    endfunction

endpackage

// File: rtl/phaser_settle_timer.sv
// Loadable down-counter; o_done marks the last enabled cycle of a loaded interval.
module phaser_settle_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/phaser_in_tap_ctrl.sv
// Request-driven sequencer for PHASER_IN fine steps, coarse counter loads and reads.
module phaser_in_tap_ctrl
    import phaser_ctrl_pkg::*;
#(
    parameter int unsigned FINE_DELAY    = 0,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned READ_LAT      = 4,
    parameter int unsigned MAX_TAP       = 63
) (
    input  logic             SYSCLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [OP_W-1:0]  REQ_OP,
    input  logic [TAP_W-1:0] REQ_DATA,
    output logic             RSP_VALID,
    output logic [TAP_W-1:0] RSP_DATA,
    output logic             RSP_ERR,
    output logic             BUSY,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             FINEENABLE,
    output logic             FINEINC,
    input  logic             FINEOVERFLOW,
    output logic             COUNTERLOADEN,
    output logic [TAP_W-1:0] COUNTERLOADVAL,
    output logic             COUNTERREADEN,
    input  logic [TAP_W-1:0] COUNTERREADVAL
);

    localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LP_RDLAT  = CNT_W'(READ_LAT);

    state_t           r_state;
    logic             r_req_ready;
    logic [OP_W-1:0]  r_op;
    logic [TAP_W-1:0] r_target;
    logic [TAP_W-1:0] r_cur_tap;
    logic             r_fineenable;
    logic             r_fineinc;
    logic             r_loaden;
    logic [TAP_W-1:0] r_loadval;
    logic             r_readen;
    logic             r_rsp_valid;
    logic [TAP_W-1:0] r_rsp_data;
    logic             r_rsp_err;
    logic             r_resp_wait;
    logic [TAP_W-1:0] r_pend_data;
    logic             r_pend_err;

    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_done;
    logic             w_tgt_illegal;

    assign w_tmr_load    = (r_state == ST_STEP) || (r_state == ST_LOAD) || (r_state == ST_RD_PULSE);
    assign w_tmr_val     = (r_state == ST_RD_PULSE) ? LP_RDLAT : LP_SETTLE;
    assign w_tmr_en      = (r_state == ST_SETTLE) || (r_state == ST_RD_WAIT);
    assign w_tgt_illegal = (32'(REQ_DATA) > MAX_TAP);

    phaser_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (SYSCLK),
        .i_rst      (RST),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_op         <= '0;
            r_target     <= '0;
            r_cur_tap    <= TAP_W'(FINE_DELAY);
            r_fineenable <= 1'b0;
            r_fineinc    <= 1'b0;
            r_loaden     <= 1'b0;
            r_loadval    <= '0;
            r_readen     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_resp_wait  <= 1'b0;
            r_pend_data  <= '0;
            r_pend_err   <= 1'b0;
        end else begin
            r_fineenable <= 1'b0;
            r_fineinc    <= 1'b0;
            r_loaden     <= 1'b0;
            r_readen     <= 1'b0;
            r_rsp_valid  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (REQ_VALID && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_op        <= REQ_OP;
                        r_target    <= REQ_DATA;
                        // Requests answered without pulses park one extra cycle in RESP
                        // (r_resp_wait) so their latency is two cycles like the decode path.
                        case (REQ_OP)
                            OP_SET_FINE: begin
                                if (w_tgt_illegal) begin
                                    r_state     <= ST_RESP;
                                    r_resp_wait <= 1'b1;
                                    r_pend_data <= r_cur_tap;
                                    r_pend_err  <= 1'b1;
                                end else if (REQ_DATA == r_cur_tap) begin
                                    r_state     <= ST_RESP;
                                    r_resp_wait <= 1'b1;
                                    r_pend_data <= r_cur_tap;
                                    r_pend_err  <= 1'b0;
                                end else begin
                                    r_state      <= ST_STEP;
                                    r_fineenable <= 1'b1;
                                    r_fineinc    <= (REQ_DATA > r_cur_tap);
                                end
                            end
                            OP_LOAD_COARSE: begin
                                r_state   <= ST_LOAD;
                                r_loaden  <= 1'b1;
                                r_loadval <= REQ_DATA;
                            end
                            OP_READ_COARSE: begin
                                r_state  <= ST_RD_PULSE;
                                r_readen <= 1'b1;
                            end
                            default: begin
                                r_state     <= ST_RESP;
                                r_resp_wait <= 1'b1;
                                r_pend_data <= '0;
                                r_pend_err  <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_STEP: begin
                    r_cur_tap <= tap_step(r_cur_tap, r_fineinc);
                    r_state   <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if ((r_op == OP_SET_FINE) && FINEOVERFLOW) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_cur_tap;
                        r_rsp_err   <= 1'b1;
                    end else if (w_tmr_done) begin
                        if (r_op != OP_SET_FINE) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_target;
                            r_rsp_err   <= 1'b0;
                        end else if (r_cur_tap == r_target) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_cur_tap;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_state      <= ST_STEP;
                            r_fineenable <= 1'b1;
                            r_fineinc    <= (r_target > r_cur_tap);
                        end
                    end
                end

                ST_LOAD: begin
                    r_state <= ST_SETTLE;
                end

                ST_RD_PULSE: begin
                    r_state <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (w_tmr_done) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= COUNTERREADVAL;
                        r_rsp_err   <= 1'b0;
                    end
                end

                ST_RESP: begin
                    if (r_resp_wait) begin
                        r_resp_wait <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_pend_data;
                        r_rsp_err   <= r_pend_err;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign REQ_READY      = r_req_ready;
    assign RSP_VALID      = r_rsp_valid;
    assign RSP_DATA       = r_rsp_data;
    assign RSP_ERR        = r_rsp_err;
    assign BUSY           = (r_state != ST_IDLE);
    assign CUR_TAP        = r_cur_tap;
    assign FINEENABLE     = r_fineenable;
    assign FINEINC        = r_fineinc;
    assign COUNTERLOADEN  = r_loaden;
    assign COUNTERLOADVAL = r_loadval;
    assign COUNTERREADEN  = r_readen;

endmodule

// File: tb/tb_phaser_in_tap_ctrl.sv
// Directed bench for phaser_in_tap_ctrl with SETTLE_CYCLES=8, READ_LAT=4, FINE_DELAY=0.
module tb_phaser_in_tap_ctrl;

    logic       SYSCLK = 1'b0;
    logic       RST;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic [5:0] REQ_DATA;
    logic       RSP_VALID;
    logic [5:0] RSP_DATA;
    logic       RSP_ERR;
    logic       BUSY;
    logic [5:0] CUR_TAP;
    logic       FINEENABLE;
    logic       FINEINC;
    logic       FINEOVERFLOW;
    logic       COUNTERLOADEN;
    logic [5:0] COUNTERLOADVAL;
    logic       COUNTERREADEN;
    logic [5:0] COUNTERREADVAL;

    int n_checks = 0;
    int n_errors = 0;

    int         fe_cyc [16];
    logic       fe_inc [16];
    int         n_fe;
    int         ld_cyc;
    logic [5:0] ld_val;
    int         n_ld;
    int         rd_cyc;
    int         n_rd;
    int         rsp_cyc [4];
    logic [5:0] rsp_dat [4];
    logic       rsp_er  [4];
    int         n_rsp;
    logic [63:0] rdy_vec;
    logic        busy_1;

    always #5 SYSCLK = ~SYSCLK;

    phaser_in_tap_ctrl #(
        .FINE_DELAY    (0),
        .SETTLE_CYCLES (8),
        .READ_LAT      (4),
        .MAX_TAP       (63)
    ) dut (
        .SYSCLK         (SYSCLK),
        .RST            (RST),
        .REQ_VALID      (REQ_VALID),
        .REQ_READY      (REQ_READY),
        .REQ_OP         (REQ_OP),
        .REQ_DATA       (REQ_DATA),
        .RSP_VALID      (RSP_VALID),
        .RSP_DATA       (RSP_DATA),
        .RSP_ERR        (RSP_ERR),
        .BUSY           (BUSY),
        .CUR_TAP        (CUR_TAP),
        .FINEENABLE     (FINEENABLE),
        .FINEINC        (FINEINC),
        .FINEOVERFLOW   (FINEOVERFLOW),
        .COUNTERLOADEN  (COUNTERLOADEN),
        .COUNTERLOADVAL (COUNTERLOADVAL),
        .COUNTERREADEN  (COUNTERREADEN),
        .COUNTERREADVAL (COUNTERREADVAL)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Holds the request until it is taken; returns one cycle after the accept edge.
    task automatic accept(input logic [1:0] op, input logic [5:0] data);
        logic r;
        logic got;
        got       = 1'b0;
        REQ_OP    = op;
        REQ_DATA  = data;
        REQ_VALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            r = REQ_READY;
            @(posedge SYSCLK);
            #1;
            if (r) begin
                got = 1'b1;
                break;
            end
        end
        REQ_VALID = 1'b0;
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Records strobes and responses for cycles 1..win after the accept edge.
    task automatic observe(input int win, input int drop_at, input int ovf_at, input int rdv_at);
        n_fe = 0; n_ld = 0; n_rd = 0; n_rsp = 0;
        ld_cyc = 0; ld_val = '0; rd_cyc = 0; rdy_vec = '0; busy_1 = 1'b0;
        for (int k = 1; k <= win; k++) begin
            if (k == drop_at) REQ_VALID = 1'b0;
            FINEOVERFLOW   = (k == ovf_at);
            COUNTERREADVAL = (k == rdv_at) ? 6'h15 : 6'h3F;
            if (k == 1) busy_1 = BUSY;
            if (k < 64) rdy_vec[k] = REQ_READY;
            if (FINEENABLE) begin
                if (n_fe < 16) begin
                    fe_cyc[n_fe] = k;
                    fe_inc[n_fe] = FINEINC;
                end
                n_fe++;
            end
            if (COUNTERLOADEN) begin
                if (n_ld == 0) begin
                    ld_cyc = k;
                    ld_val = COUNTERLOADVAL;
                end
                n_ld++;
            end
            if (COUNTERREADEN) begin
                if (n_rd == 0) rd_cyc = k;
                n_rd++;
            end
            if (RSP_VALID) begin
                if (n_rsp < 4) begin
                    rsp_cyc[n_rsp] = k;
                    rsp_dat[n_rsp] = RSP_DATA;
                    rsp_er[n_rsp]  = RSP_ERR;
                end
                n_rsp++;
            end
            @(posedge SYSCLK);
            #1;
        end
        FINEOVERFLOW   = 1'b0;
        COUNTERREADVAL = 6'h3F;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(posedge SYSCLK);
        #1;
        RST = 1'b0;
        @(posedge SYSCLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST            = 1'b1;
        REQ_VALID      = 1'b0;
        REQ_OP         = 2'b00;
        REQ_DATA       = '0;
        FINEOVERFLOW   = 1'b0;
        COUNTERREADVAL = 6'h3F;

        // Reset state
        repeat (3) @(posedge SYSCLK);
        #1;
        check("rst_ready", REQ_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_tap", CUR_TAP, 0);
        check("rst_rspv", RSP_VALID, 0);
        check("rst_fe", FINEENABLE, 0);
        check("rst_ld", COUNTERLOADEN, 0);
        RST = 1'b0;
        @(posedge SYSCLK);
        #1;
        check("post_rst_ready", REQ_READY, 1);

        // SET_FINE 3 from tap 0
        accept(2'b00, 6'd3);
        observe(30, 0, 0, 0);
        check("s3_busy", busy_1, 1);
        check("s3_nfe", n_fe, 3);
        check("s3_fe0", fe_cyc[0], 1);
        check("s3_fe1", fe_cyc[1], 10);
        check("s3_fe2", fe_cyc[2], 19);
        check("s3_inc", {fe_inc[0], fe_inc[1], fe_inc[2]}, 3'b111);
        check("s3_nrsp", n_rsp, 1);
        check("s3_rspc", rsp_cyc[0], 28);
        check("s3_data", rsp_dat[0], 3);
        check("s3_err", rsp_er[0], 0);
        check("s3_tap", CUR_TAP, 3);
        check("s3_hold", RSP_DATA, 3);

        // SET_FINE 1 from tap 3
        accept(2'b00, 6'd1);
        observe(21, 0, 0, 0);
        check("s1_nfe", n_fe, 2);
        check("s1_fe1", fe_cyc[1], 10);
        check("s1_inc", {fe_inc[0], fe_inc[1]}, 2'b00);
        check("s1_rspc", rsp_cyc[0], 19);
        check("s1_data", rsp_dat[0], 1);
        check("s1_err", rsp_er[0], 0);

        // SET_FINE to the current tap
        accept(2'b00, 6'd1);
        observe(4, 0, 0, 0);
        check("same_nfe", n_fe, 0);
        check("same_rspc", rsp_cyc[0], 2);
        check("same_data", rsp_dat[0], 1);
        check("same_err", rsp_er[0], 0);

        // Overflow during second settle, starting from tap 0
        do_reset();
        accept(2'b00, 6'd10);
        observe(16, 0, 12, 0);
        check("ovf_nfe", n_fe, 2);
        check("ovf_nrsp", n_rsp, 1);
        check("ovf_rspc", rsp_cyc[0], 13);
        check("ovf_err", rsp_er[0], 1);
        check("ovf_data", rsp_dat[0], 2);
        check("ovf_tap", CUR_TAP, 2);

        // LOAD_COARSE 0x2A
        accept(2'b01, 6'h2A);
        observe(12, 0, 0, 0);
        check("ld_n", n_ld, 1);
        check("ld_cyc", ld_cyc, 1);
        check("ld_val", ld_val, 6'h2A);
        check("ld_rspc", rsp_cyc[0], 10);
        check("ld_data", rsp_dat[0], 6'h2A);
        check("ld_err", rsp_er[0], 0);
        check("ld_valhold", COUNTERLOADVAL, 6'h2A);

        // READ_COARSE, read value valid only on the capture cycle
        accept(2'b10, 6'd0);
        observe(8, 0, 0, 5);
        check("rd_n", n_rd, 1);
        check("rd_cyc", rd_cyc, 1);
        check("rd_rspc", rsp_cyc[0], 6);
        check("rd_data", rsp_dat[0], 6'h15);
        check("rd_err", rsp_er[0], 0);

        // Reserved opcode
        accept(2'b11, 6'd5);
        observe(4, 0, 0, 0);
        check("rsv_rspc", rsp_cyc[0], 2);
        check("rsv_err", rsp_er[0], 1);
        check("rsv_data", rsp_dat[0], 0);
        check("rsv_nfe", n_fe, 0);

        // Back-to-back: LOAD_COARSE 7 held valid behind a reserved-op request
        accept(2'b11, 6'd0);
        REQ_VALID = 1'b1;
        REQ_OP    = 2'b01;
        REQ_DATA  = 6'd7;
        observe(16, 4, 0, 0);
        check("b2b_rdy12", rdy_vec[2:1], 2'b00);
        check("b2b_rdy3", rdy_vec[3], 1);
        check("b2b_rsp0c", rsp_cyc[0], 2);
        check("b2b_rsp0e", rsp_er[0], 1);
        check("b2b_ldcyc", ld_cyc, 4);
        check("b2b_nrsp", n_rsp, 2);
        check("b2b_rsp1c", rsp_cyc[1], 13);
        check("b2b_rsp1d", rsp_dat[1], 7);

        // Reset during the second settle of SET_FINE 5 (tap 2 -> 5)
        accept(2'b00, 6'd5);
        observe(11, 0, 0, 0);
        check("mid_nfe", n_fe, 2);
        RST = 1'b1;
        @(posedge SYSCLK);
        #1;
        check("mid_fe", FINEENABLE, 0);
        check("mid_ld", COUNTERLOADEN, 0);
        check("mid_rd", COUNTERREADEN, 0);
        check("mid_tap", CUR_TAP, 0);
        check("mid_rspv", RSP_VALID, 0);
        check("mid_ready", REQ_READY, 0);
        RST = 1'b0;
        @(posedge SYSCLK);
        #1;
        check("mid_ready_after", REQ_READY, 1);
        observe(30, 0, 0, 0);
        check("mid_nrsp", n_rsp, 0);
        check("mid_nfe_after", n_fe, 0);
        check("mid_tap_after", CUR_TAP, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
